// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: branch condition encodings,
// 2-bit BHT counter states and the saturating counter update helper.
package branch_resolve_unit_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] CNT_SNT  = 2'b00;
    localparam logic [1:0] CNT_WNT  = 2'b01;
    localparam logic [1:0] CNT_WT   = 2'b10;
    localparam logic [1:0] CNT_ST   = 2'b11;
    localparam logic [1:0] BHT_INIT = CNT_WNT;

    // Saturating 2-bit counter step: towards ST on taken, towards SNT otherwise.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-facing bus of the branch resolve unit: IF lookup, EX resolve
// request and the resolution result back to the hazard/PC logic.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic            ex_is_branch;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_op1;
    logic [XLEN-1:0] ex_op2;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            stall;
    logic            flush;
    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic [XLEN-1:0] res_redirect_pc;
    logic            res_illegal;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_funct3, ex_op1, ex_op2,
               ex_pc, ex_target, ex_pred_taken, stall, flush,
        input  if_pred_taken, res_valid, res_taken, res_mispredict,
               res_redirect_pc, res_illegal
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_funct3, ex_op1, ex_op2,
               ex_pc, ex_target, ex_pred_taken, stall, flush,
        output if_pred_taken, res_valid, res_taken, res_mispredict,
               res_redirect_pc, res_illegal
    );
endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluator. Reserved encodings 010/011
// resolve as not-taken and raise illegal.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            taken,
    output logic            illegal
);

    // Decode funct3 into the selected compare result.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BR_EQ:   taken = (op1 == op2);
            BR_NE:   taken = (op1 != op2);
            BR_LT:   taken = ($signed(op1) <  $signed(op2));
            BR_GE:   taken = ($signed(op1) >= $signed(op2));
            BR_LTU:  taken = (op1 <  op2);
            BR_GEU:  taken = (op1 >= op2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves EX conditional branches, owns the bimodal
// BHT looked up by IF, produces taken/mispredict/redirect and keeps
// saturating branch and mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int PIPE_STAGE  = 1,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus,
    output logic [CNT_W-1:0]      perf_branches,
    output logic [CNT_W-1:0]      perf_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]      bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic            resolve;
    logic            cond_taken;
    logic            cond_illegal;
    logic            mispredict;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;
    logic            unused_if_pc;

    assign if_idx  = bus.if_pc[IDX_W+1:2];
    assign ex_idx  = bus.ex_pc[IDX_W+1:2];
    assign unused_if_pc = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0]};

    assign resolve = bus.ex_valid & bus.ex_is_branch & ~bus.flush & ~bus.stall;

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .funct3  (bus.ex_funct3),
        .op1     (bus.ex_op1),
        .op2     (bus.ex_op2),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign mispredict  = cond_taken ^ bus.ex_pred_taken;
    assign pc_plus4    = bus.ex_pc + XLEN'(4);
    assign redirect_pc = cond_taken ? bus.ex_target : pc_plus4;

    // No bypass: a same-cycle update to the looked-up entry shows next cycle.
    assign bus.if_pred_taken = bht[if_idx][1];

    // BHT training on every resolved branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_INIT;
        end else if (resolve) begin
            bht[ex_idx] <= cnt_next(bht[ex_idx], cond_taken);
        end
    end

    // Performance counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (resolve) begin
            if (perf_branches != '1) perf_branches <= perf_branches + CNT_W'(1);
            if (mispredict && (perf_mispredicts != '1))
                perf_mispredicts <= perf_mispredicts + CNT_W'(1);
        end
    end

    generate
        if (PIPE_STAGE != 0) begin : g_reg
            logic            r_valid;
            logic            r_taken;
            logic            r_mispredict;
            logic            r_illegal;
            logic [XLEN-1:0] r_redirect_pc;

            // Result register: stall freezes everything, payload loads on resolve.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid       <= 1'b0;
                    r_taken       <= 1'b0;
                    r_mispredict  <= 1'b0;
                    r_illegal     <= 1'b0;
                    r_redirect_pc <= '0;
                end else if (!bus.stall) begin
                    r_valid <= resolve;
                    if (resolve) begin
                        r_taken       <= cond_taken;
                        r_mispredict  <= mispredict;
                        r_illegal     <= cond_illegal;
                        r_redirect_pc <= redirect_pc;
                    end
                end
            end

            assign bus.res_valid       = r_valid;
            assign bus.res_taken       = r_taken;
            assign bus.res_mispredict  = r_mispredict;
            assign bus.res_illegal     = r_illegal;
            assign bus.res_redirect_pc = r_redirect_pc;
        end else begin : g_comb
            assign bus.res_valid       = resolve;
            assign bus.res_taken       = cond_taken;
            assign bus.res_mispredict  = mispredict;
            assign bus.res_illegal     = cond_illegal;
            assign bus.res_redirect_pc = redirect_pc;
        end
    endgenerate

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (XLEN=32, 16 entries, registered results).
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic clk;
    logic rst_n;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(
        .XLEN(32), .BHT_ENTRIES(16), .PIPE_STAGE(1), .CNT_W(32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  mdl_bht [16];
    int          mdl_br;
    int          mdl_mis;
    logic        mon_en;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic mdl_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl_bht[i] = 2'b01;
        mdl_br  = 0;
        mdl_mis = 0;
    endtask

    // Drives one EX cycle at negedge; returns just after the capturing posedge.
    task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic pred,
                         input logic st, input logic fl);
        exp_t e;
        logic t;
        logic [3:0] ix;
        @(negedge clk);
        bus.ex_valid      = 1'b1;
        bus.ex_is_branch  = 1'b1;
        bus.ex_funct3     = f3;
        bus.ex_op1        = a;
        bus.ex_op2        = b;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_pred_taken = pred;
        bus.stall         = st;
        bus.flush         = fl;
        if (!st && !fl) begin
            t       = mdl_taken(f3, a, b);
            e.taken = t;
            e.mis   = t ^ pred;
            e.ill   = (f3 == 3'b010) || (f3 == 3'b011);
            e.rd    = t ? tgt : pc + 32'd4;
            ix      = pc[5:2];
            if (t && mdl_bht[ix] != 2'b11) mdl_bht[ix] = mdl_bht[ix] + 2'd1;
            if (!t && mdl_bht[ix] != 2'b00) mdl_bht[ix] = mdl_bht[ix] - 2'd1;
            mdl_br++;
            if (e.mis) mdl_mis++;
            if (mon_en) sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic check_pred(input logic [31:0] pc);
        logic [3:0] ix;
        idle();
        bus.if_pc = pc;
        ix = pc[5:2];
        #1;
        chk("pred", bus.if_pred_taken, mdl_bht[ix][1]);
    endtask

    // Scoreboard monitor: every valid result pops and compares one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst_n && bus.res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("res_taken",    bus.res_taken,       e.taken);
                    chk("res_mispred",  bus.res_mispredict,  e.mis);
                    chk("res_illegal",  bus.res_illegal,     e.ill);
                    chk("res_redirect", bus.res_redirect_pc, e.rd);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        mon_en = 1'b0;
        bus.if_pc = 32'h0; bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_funct3 = 0;
        bus.ex_op1 = 0; bus.ex_op2 = 0; bus.ex_pc = 0; bus.ex_target = 0;
        bus.ex_pred_taken = 0; bus.stall = 0; bus.flush = 0;
        mdl_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid",    bus.res_valid, 0);
        chk("rst_redirect", bus.res_redirect_pc, 0);
        chk("rst_perf_br",  perf_branches, 0);
        chk("rst_perf_mis", perf_mispredicts, 0);
        chk("rst_pred",     bus.if_pred_taken, 0);
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Signed/unsigned compares with op1=5, op2=-2, plus EQ/NE both ways.
        drive(32'h104, 32'h400, BR_LT,  32'd5, 32'hFFFF_FFFE, 1'b0, 0, 0);
        drive(32'h108, 32'h404, BR_GE,  32'd5, 32'hFFFF_FFFE, 1'b1, 0, 0);
        drive(32'h10C, 32'h408, BR_LTU, 32'd5, 32'hFFFF_FFFE, 1'b0, 0, 0);
        drive(32'h110, 32'h40C, BR_GEU, 32'd5, 32'hFFFF_FFFE, 1'b1, 0, 0);
        drive(32'h114, 32'h410, BR_EQ,  32'd9, 32'd9, 1'b1, 0, 0);
        drive(32'h118, 32'h414, BR_NE,  32'd9, 32'd9, 1'b0, 0, 0);
        drive(32'h11C, 32'h418, BR_NE,  32'd9, 32'd8, 1'b1, 0, 0);
        idle();

        // BHT training at pc=0x40: three taken then two not-taken.
        check_pred(32'h40);
        for (int i = 0; i < 3; i++) begin
            drive(32'h40, 32'h60, BR_EQ, 32'd3, 32'd3, 1'b1, 0, 0);
            check_pred(32'h40);
        end
        for (int i = 0; i < 2; i++) begin
            drive(32'h40, 32'h60, BR_NE, 32'd3, 32'd3, 1'b1, 0, 0);
            check_pred(32'h40);
        end

        // Mispredicted taken branch, PC wrap, illegal encoding.
        drive(32'h80, 32'h100, BR_EQ, 32'd1, 32'd1, 1'b0, 0, 0);
        drive(32'hFFFF_FFFC, 32'h10, BR_EQ, 32'd1, 32'd2, 1'b0, 0, 0);
        drive(32'h8C, 32'h200, 3'b010, 32'd1, 32'd1, 1'b1, 0, 0);
        drive(32'h90, 32'h200, 3'b011, 32'd0, 32'd0, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive($urandom_range(255, 0) << 2, $urandom, 3'(i), $urandom, $urandom_range(3, 0), 1'($urandom), 0, 0);
        end
        idle();
        repeat (3) idle();
        chk("sb_drained",   sb.size(), 0);
        chk("perf_br",      perf_branches, mdl_br);
        chk("perf_mis",     perf_mispredicts, mdl_mis);
        check_pred(32'h80);

        // Stall holds results, BHT and perf; flush kills the result.
        mon_en = 1'b0;
        drive(32'h200, 32'h300, BR_EQ, 32'd7, 32'd7, 1'b1, 0, 0);
        chk("st_valid0",    bus.res_valid, 1);
        chk("st_redir0",    bus.res_redirect_pc, 32'h300);
        drive(32'h44, 32'h500, BR_EQ, 32'd1, 32'd1, 1'b0, 1, 0);
        chk("st_valid1",    bus.res_valid, 1);
        chk("st_redir1",    bus.res_redirect_pc, 32'h300);
        chk("st_mis1",      bus.res_mispredict, 0);
        drive(32'h44, 32'h500, BR_EQ, 32'd1, 32'd1, 1'b0, 1, 0);
        chk("st_valid2",    bus.res_valid, 1);
        chk("st_perf_br",   perf_branches, mdl_br);
        chk("st_perf_mis",  perf_mispredicts, mdl_mis);
        drive(32'h44, 32'h500, BR_EQ, 32'd1, 32'd1, 1'b0, 0, 1);
        chk("fl_valid",     bus.res_valid, 0);
        chk("fl_perf_br",   perf_branches, mdl_br);
        check_pred(32'h44);

        // Asynchronous reset in the middle of a resolve.
        bus.if_pc = 32'h80;
        drive(32'h80, 32'h100, BR_EQ, 32'd2, 32'd2, 1'b0, 0, 0);
        chk("mid_valid",    bus.res_valid, 1);
        chk("mid_pred",     bus.if_pred_taken, mdl_bht[0][1]);
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("ar_valid",     bus.res_valid, 0);
        chk("ar_taken",     bus.res_taken, 0);
        chk("ar_mis",       bus.res_mispredict, 0);
        chk("ar_redirect",  bus.res_redirect_pc, 0);
        chk("ar_perf_br",   perf_branches, 0);
        chk("ar_perf_mis",  perf_mispredicts, 0);
        chk("ar_pred",      bus.if_pred_taken, 0);
        idle();
        for (int i = 0; i < 16; i++) begin
            bus.if_pc = 32'(i) << 2;
            #1;
            chk("ar_bht", bus.if_pred_taken, 0);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        drive(32'h80, 32'h100, BR_GEU, 32'd4, 32'd4, 1'b0, 0, 0);
        check_pred(32'h80);
        chk("post_perf_br", perf_branches, mdl_br);
        repeat (2) idle();
        chk("sb_drained2",  sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
